// File: rtl/neg_sched_pkg.sv
// rtl/neg_sched_pkg.sv - shared types and constants for the round-robin negator scheduler
package neg_sched_pkg;

   localparam int STAT_W = 16;

   // Tag id storage is sized for the largest supported requester count (16).
   // The scheduler derives its own ID_W = $clog2(NUM_REQ) and zero-extends into this field.
   localparam int ID_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_e;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/negator_tag_pipe.sv
// rtl/negator_tag_pipe.sv - fixed-depth tag shift register that tracks negator occupancy
module negator_tag_pipe
   import neg_sched_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clock,
   input  logic reset,
   input  tag_t tag_in,
   output tag_t tag_out,
   output logic empty
);

   tag_t stage [DEPTH];

   // Shift tags one stage per cycle; reset discards everything in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tag_out = stage[DEPTH-1];

   // The pipe is empty when no stage holds a valid tag.
   always_comb begin
      empty = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (stage[i].valid) begin
            empty = 1'b0;
         end
      end
   end

endmodule

// File: rtl/negator_rr_scheduler.sv
// rtl/negator_rr_scheduler.sv - round-robin sharing of one pipelined negator; optional NEG_SCHED_STATS_EN grant counters
module negator_rr_scheduler
   import neg_sched_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 64,
   parameter int NEG_LATENCY = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          sched_enable,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          neg_in_valid,
   output logic [DATA_WIDTH-1:0]         neg_in_data,
   input  logic                          neg_out_valid,
   input  logic [DATA_WIDTH-1:0]         neg_out_data,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic                          busy,
   output logic                          tag_error
`ifdef NEG_SCHED_STATS_EN
   ,
   output logic [NUM_REQ*STAT_W-1:0]     stat_grant_count
`endif
);

   localparam int REQ_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CAND_W   = REQ_ID_W + 1;
   localparam logic [NUM_REQ-1:0] REQ_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   sched_state_e          state_q, state_d;
   logic [REQ_ID_W-1:0]   ptr_q;
   logic [REQ_ID_W-1:0]   grant_idx;
   logic                  grant_found;
   logic                  grant;
   logic [CAND_W-1:0]     cand;
   tag_t                  issue_tag;
   tag_t                  pipe_out;
   logic                  pipe_empty;
   logic                  in_flight;
   logic [NUM_REQ-1:0]    resp_onehot;

   assign in_flight = issue_tag.valid | ~pipe_empty;
   assign busy      = (state_q != IDLE) | in_flight;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: enable wins over drain completion so a quick re-enable goes straight back to RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sched_enable) state_d = RUN;
         RUN:     if (!sched_enable) state_d = DRAIN;
         DRAIN:   if (sched_enable) state_d = RUN;
                  else if (!in_flight) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Round-robin search from the pointer with wrap; gating on sched_enable means a
   // request in the same cycle enable drops is not granted.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = ptr_q;
      cand        = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr_q} + CAND_W'(i);
         if (cand >= CAND_W'(NUM_REQ)) begin
            cand = cand - CAND_W'(NUM_REQ);
         end
         if (!grant_found && req_valid[cand[REQ_ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[REQ_ID_W-1:0];
         end
      end
      grant     = grant_found & (state_q == RUN) & sched_enable;
      req_ready = grant ? (REQ_ONE << grant_idx) : '0;
   end

   // Pointer advances past the granted requester, holding when nothing is granted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else if (grant) begin
         ptr_q <= (grant_idx == REQ_ID_W'(NUM_REQ-1)) ? '0 : grant_idx + REQ_ID_W'(1);
      end
   end

   // Issue stage: registered operand toward the negator, with its tag launched alongside.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         neg_in_valid <= 1'b0;
         neg_in_data  <= '0;
         issue_tag    <= '0;
      end else begin
         neg_in_valid    <= grant;
         issue_tag.valid <= grant;
         issue_tag.id    <= grant ? ID_W'(grant_idx) : '0;
         if (grant) begin
            neg_in_data <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   negator_tag_pipe #(
      .DEPTH (NEG_LATENCY)
   ) u_tag_pipe (
      .clock   (clock),
      .reset   (reset),
      .tag_in  (issue_tag),
      .tag_out (pipe_out),
      .empty   (pipe_empty)
   );

   // Decode the emerging tag id into the response strobe.
   always_comb begin
      resp_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         resp_onehot[i] = (pipe_out.id == ID_W'(i));
      end
   end

   // Return stage: route matched results; any valid/tag disagreement is latched as an error.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         resp_valid <= '0;
         resp_data  <= '0;
         tag_error  <= 1'b0;
      end else begin
         resp_valid <= (neg_out_valid & pipe_out.valid) ? resp_onehot : '0;
         if (neg_out_valid & pipe_out.valid) begin
            resp_data <= neg_out_data;
         end
         if (neg_out_valid ^ pipe_out.valid) begin
            tag_error <= 1'b1;
         end
      end
   end

`ifdef NEG_SCHED_STATS_EN
   logic [STAT_W-1:0] grant_cnt [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      // Saturating per-requester grant counter.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            grant_cnt[g] <= '0;
         end else if (grant && (grant_idx == REQ_ID_W'(g)) && (grant_cnt[g] != '1)) begin
            grant_cnt[g] <= grant_cnt[g] + STAT_W'(1);
         end
      end
      assign stat_grant_count[g*STAT_W +: STAT_W] = grant_cnt[g];
   end
`endif

endmodule

// File: tb/tb_negator_rr_scheduler.sv
// tb/tb_negator_rr_scheduler.sv - directed self-checking bench for negator_rr_scheduler
module tb_negator_rr_scheduler;

   localparam int NUM_REQ = 4;
   localparam int DW      = 64;

   logic              clock = 1'b0;
   logic              reset;
   logic              sched_enable;
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ*DW-1:0] req_data;
   logic [NUM_REQ-1:0] req_ready;
   logic              neg_in_valid;
   logic [DW-1:0]     neg_in_data;
   logic              neg_out_valid;
   logic [DW-1:0]     neg_out_data;
   logic [NUM_REQ-1:0] resp_valid;
   logic [DW-1:0]     resp_data;
   logic              busy;
   logic              tag_error;
`ifdef NEG_SCHED_STATS_EN
   logic [NUM_REQ*16-1:0] stat_grant_count;
`endif

   logic              m_valid = 1'b0;
   logic [DW-1:0]     m_data  = '0;
   logic              inj;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] opnd [NUM_REQ];
   logic [DW-1:0] negd [NUM_REQ];

   negator_rr_scheduler #(
      .NUM_REQ     (NUM_REQ),
      .DATA_WIDTH  (DW),
      .NEG_LATENCY (1)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .sched_enable  (sched_enable),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .neg_in_valid  (neg_in_valid),
      .neg_in_data   (neg_in_data),
      .neg_out_valid (neg_out_valid),
      .neg_out_data  (neg_out_data),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .busy          (busy),
      .tag_error     (tag_error)
`ifdef NEG_SCHED_STATS_EN
      ,
      .stat_grant_count (stat_grant_count)
`endif
   );

   always #5 clock = ~clock;

   // One-cycle negator model; inj forces a spurious output valid.
   always @(posedge clock) begin
      m_valid <= neg_in_valid;
      m_data  <= -neg_in_data;
   end
   assign neg_out_valid = m_valid | inj;
   assign neg_out_data  = m_data;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      sched_enable = 1'b0;
      req_valid    = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      opnd[0] = 64'h0000_0000_0000_0001;  negd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      opnd[1] = 64'h7FFF_FFFF_FFFF_FFFF;  negd[1] = 64'h8000_0000_0000_0001;
      opnd[2] = 64'h0000_0000_0000_0000;  negd[2] = 64'h0000_0000_0000_0000;
      opnd[3] = 64'h8000_0000_0000_0000;  negd[3] = 64'h8000_0000_0000_0000;

      reset        = 1'b1;
      sched_enable = 1'b0;
      req_valid    = '0;
      req_data     = '0;
      inj          = 1'b0;
      step();
      step();

      // Reset state.
      chk("rst_req_ready", req_ready, 0);
      chk("rst_neg_in_valid", neg_in_valid, 0);
      chk("rst_neg_in_data", neg_in_data, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tag_error", tag_error, 0);

      // Single request.
      reset        = 1'b0;
      sched_enable = 1'b1;
      step();
      req_data[63:0] = 64'd5;
      req_valid      = 4'b0001;
      #1;
      chk("single_ready", req_ready, 4'b0001);
      step();
      req_valid = '0;
      chk("single_neg_in_valid", neg_in_valid, 1);
      chk("single_neg_in_data", neg_in_data, 64'd5);
      chk("single_busy", busy, 1);
      step();
      chk("single_resp_early", resp_valid, 0);
      step();
      chk("single_resp_valid", resp_valid, 4'b0001);
      chk("single_resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFB);

      // Fairness with all requesters valid.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = opnd[i];
      sched_enable = 1'b1;
      step();
      for (int c = 0; c < 11; c++) begin
         req_valid = (c < 8) ? 4'hF : 4'h0;
         #1;
         chk($sformatf("fair_ready_c%0d", c), req_ready, (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000);
         if (c >= 3) begin
            chk($sformatf("fair_resp_valid_c%0d", c), resp_valid, 4'b0001 << ((c - 3) % 4));
            chk($sformatf("fair_resp_data_c%0d", c), resp_data, negd[(c - 3) % 4]);
         end else begin
            chk($sformatf("fair_resp_idle_c%0d", c), resp_valid, 0);
         end
         step();
      end

      // Wrap and skip: bring pointer to 3, then only req 1 valid.
      req_valid = 4'hF;
      step();
      step();
      step();
      req_valid = 4'b0010;
      #1;
      chk("skip_ready", req_ready, 4'b0010);
      step();
      req_valid = 4'b0110;
      #1;
      chk("skip_ptr_is_2", req_ready, 4'b0100);
      step();

      // Drain: pointer at 3, three grants then disable.
      req_valid = 4'hF;
      #1;
      chk("drain_g0", req_ready, 4'b1000);
      step();
      chk("drain_g1", req_ready, 4'b0001);
      step();
      chk("drain_g2", req_ready, 4'b0010);
      step();
      sched_enable = 1'b0;
      #1;
      chk("drain_same_cycle_ready", req_ready, 0);
      chk("drain_resp0_valid", resp_valid, 4'b1000);
      chk("drain_resp0_data", resp_data, negd[3]);
      chk("drain_busy0", busy, 1);
      step();
      chk("drain_ready1", req_ready, 0);
      chk("drain_resp1_valid", resp_valid, 4'b0001);
      chk("drain_resp1_data", resp_data, negd[0]);
      chk("drain_busy1", busy, 1);
      step();
      chk("drain_ready2", req_ready, 0);
      chk("drain_resp2_valid", resp_valid, 4'b0010);
      chk("drain_resp2_data", resp_data, negd[1]);
      chk("drain_busy2", busy, 1);
      step();
      chk("drain_idle_busy", busy, 0);
      chk("drain_idle_resp", resp_valid, 0);
      chk("drain_idle_ready", req_ready, 0);
      req_valid = '0;

      // Reset mid-flight.
      do_reset();
      sched_enable   = 1'b1;
      step();
      req_data[63:0] = 64'd5;
      req_valid      = 4'b0001;
      step();
      req_valid = '0;
      step();
      chk("midrst_busy_before", busy, 1);
      reset = 1'b1;
      #1;
      chk("midrst_ready", req_ready, 0);
      chk("midrst_neg_in_valid", neg_in_valid, 0);
      chk("midrst_resp_valid", resp_valid, 0);
      chk("midrst_resp_data", resp_data, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_tag_error", tag_error, 0);
      step();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("midrst_no_resp_c%0d", c), resp_valid, 0);
         chk($sformatf("midrst_no_err_c%0d", c), tag_error, 0);
      end

      // Mismatch: spurious negator output with an empty tag pipe.
      inj = 1'b1;
      step();
      inj = 1'b0;
      chk("mismatch_tag_error", tag_error, 1);
      chk("mismatch_no_resp", resp_valid, 0);
      step();
      step();
      chk("mismatch_sticky", tag_error, 1);
      chk("mismatch_no_resp_after", resp_valid, 0);

`ifdef NEG_SCHED_STATS_EN
      do_reset();
      sched_enable = 1'b1;
      step();
      req_valid = 4'b0001;
      repeat (70000) step();
      req_valid = '0;
      chk("stat_req0_saturated", stat_grant_count[15:0], 16'hFFFF);
      chk("stat_req1_zero", stat_grant_count[31:16], 16'h0000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
